// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus arbiter.
// Slave id 0 is reserved to mean "no slave selected".
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  localparam int SLAVE_NONE = 0;

  // Width needed to encode n distinct ids, never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first eligible index after rr_last,
// wrapping modulo N.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [0:N-1] eligible,
  input  logic [W-1:0] rr_last,
  output logic         found,
  output logic [W-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(rr_last) + k) % N;
      if (!found && eligible[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with slave-stall watchdog.
// Drives {master_sel, slave_sel} to the serial bus interconnect.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NO_MASTERS = 2,
  parameter int NO_SLAVES  = 3,
  parameter int S_ID_WIDTH = id_width(NO_SLAVES + 1),
  parameter int M_ID_WIDTH = id_width(NO_MASTERS),
  parameter int MAX_WAIT   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [0:NO_MASTERS-1]                 req_M,
  input  logic [0:NO_MASTERS-1][S_ID_WIDTH-1:0] sid_M,
  input  logic                                  ready,
  output logic [S_ID_WIDTH+M_ID_WIDTH-1:0]      bus_state,
  output logic [0:NO_MASTERS-1]                 grant_M,
  output logic [0:NO_MASTERS-1]                 timeout_M,
  output logic                                  busy
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int BW = S_ID_WIDTH + M_ID_WIDTH;

  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);
  localparam logic [M_ID_WIDTH-1:0] RR_INIT =
    M_ID_WIDTH'(NO_MASTERS - 1);
  localparam logic [S_ID_WIDTH:0] SID_MAX =
    (S_ID_WIDTH + 1)'(NO_SLAVES);
  localparam logic [S_ID_WIDTH-1:0] SID_NONE =
    S_ID_WIDTH'(SLAVE_NONE);

  arb_state_t                state;
  logic [CW-1:0]             wait_cnt;
  logic [M_ID_WIDTH-1:0]     rr_last;
  logic [M_ID_WIDTH-1:0]     owner;
  logic [M_ID_WIDTH-1:0]     pick_idx;
  logic                      found;
  logic [0:NO_MASTERS-1]     eligible;
  logic [0:NO_MASTERS-1]     pick_onehot;
  logic [0:NO_MASTERS-1]     owner_onehot;
  logic                      owner_req;
  logic                      stall_expired;
  logic [CW-1:0]             wait_nxt;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NO_MASTERS; i++) begin
      eligible[i] = req_M[i]
                 && (sid_M[i] != SID_NONE)
                 && ({1'b0, sid_M[i]} <= SID_MAX);
    end
  end

  rr_picker #(
    .N (NO_MASTERS),
    .W (M_ID_WIDTH)
  ) u_pick (
    .eligible (eligible),
    .rr_last  (rr_last),
    .found    (found),
    .idx      (pick_idx)
  );

  assign owner     = bus_state[BW-1 -: M_ID_WIDTH];
  assign owner_req = req_M[owner];

  always_comb begin
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
    owner_onehot          = '0;
    owner_onehot[owner]   = 1'b1;
  end

  // Watchdog counts consecutive ready-low cycles, never wrapping.
  assign stall_expired = !ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    wait_nxt = wait_cnt;
    if (ready)
      wait_nxt = '0;
    else if (wait_cnt != WAIT_SAT)
      wait_nxt = wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_state <= '0;
      grant_M   <= '0;
      timeout_M <= '0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
      rr_last   <= RR_INIT;
    end else begin
      unique case (state)
        IDLE: begin
          timeout_M <= '0;
          if (found) begin
            bus_state <= {pick_idx, sid_M[pick_idx]};
            grant_M   <= pick_onehot;
            busy      <= 1'b1;
            rr_last   <= pick_idx;
            wait_cnt  <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          wait_cnt <= wait_nxt;
          if (!owner_req || stall_expired) begin
            // A normal release outranks a coincident timeout.
            if (owner_req)
              timeout_M <= owner_onehot;
            grant_M                   <= '0;
            busy                      <= 1'b0;
            bus_state[S_ID_WIDTH-1:0] <= SID_NONE;
            state                     <= RELEASE;
          end
        end
        RELEASE: begin
          timeout_M <= '0;
          state     <= IDLE;
        end
        default: begin
          grant_M   <= '0;
          timeout_M <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
